// File: rtl/dmac_arb_pkg.sv
// Shared types and constants for the DMAC packet-aware request arbiter.
package dmac_arb_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic LOCK_RST = 1'b0;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Reset value of last_id: the highest index, so the search begins at master 0.
    function automatic int last_id_rst(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/dmac_rr_picker.sv
// Combinational rotate-priority encoder: first set request at or after start wins.
module dmac_rr_picker
    import dmac_arb_pkg::*;
#(
    parameter int N_MASTER = 4,
    parameter int ID_W     = id_width(N_MASTER)
) (
    input  logic [N_MASTER-1:0] req,
    input  logic [ID_W-1:0]     start,
    output logic                gnt_valid,
    output logic [ID_W-1:0]     gnt_idx
);

    function automatic logic [ID_W-1:0] rot(input logic [ID_W-1:0] s, input int k);
        int sum;
        sum = int'(s) + k;
        if (sum >= N_MASTER) sum = sum - N_MASTER;
        return ID_W'(sum);
    endfunction

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = N_MASTER - 1; k >= 0; k--) begin
            if (req[rot(start, k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = rot(start, k);
            end
        end
    end

endmodule

// File: rtl/dmac_rr_arbiter.sv
// Packet-aware N-to-1 arbiter with a single registered output stage.
// DMAC_ARB_RR_EN selects round-robin; without it master 0 has fixed highest priority.
//
// state  | meaning
// S_IDLE | output register empty
// S_BUSY | output register holds a beat
module dmac_rr_arbiter
    import dmac_arb_pkg::*;
#(
    parameter int N_MASTER  = 4,
    parameter int DATA_SIZE = 32,
    parameter int ID_W      = id_width(N_MASTER)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 src_valid_i [N_MASTER],
    output logic                 src_ready_o [N_MASTER],
    input  logic [DATA_SIZE-1:0] src_data_i  [N_MASTER],
    input  logic                 src_last_i  [N_MASTER],
    output logic                 dst_valid_o,
    input  logic                 dst_ready_i,
    output logic [DATA_SIZE-1:0] dst_data_o,
    output logic                 dst_last_o,
    output logic [ID_W-1:0]      dst_id_o
);

    state_t              state_q;
    state_t              state_d;
    logic                lock_q;
    logic [ID_W-1:0]     lock_id_q;
    logic [N_MASTER-1:0] req;
    logic [ID_W-1:0]     start;
    logic                gnt_valid;
    logic [ID_W-1:0]     gnt_idx;
    logic                slot_open;
    logic                accept;

    // While a packet is open only its owner may compete.
    always_comb begin
        req = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            req[i] = src_valid_i[i] && (!lock_q || (lock_id_q == ID_W'(i)));
        end
    end

`ifdef DMAC_ARB_RR_EN
    logic [ID_W-1:0] last_id_q;

    always_comb begin
        start = (int'(last_id_q) == N_MASTER - 1) ? '0 : last_id_q + ID_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id_q <= ID_W'(last_id_rst(N_MASTER));
        end else if (accept) begin
            last_id_q <= gnt_idx;
        end
    end
`else
    assign start = '0;
`endif

    dmac_rr_picker #(
        .N_MASTER (N_MASTER),
        .ID_W     (ID_W)
    ) u_picker (
        .req       (req),
        .start     (start),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign slot_open = (state_q == S_IDLE) || dst_ready_i;
    assign accept    = rst_n && slot_open && gnt_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        for (int i = 0; i < N_MASTER; i++) begin
            src_ready_o[i] = 1'b0;
        end
        case (state_q)
            S_IDLE:  if (accept) state_d = S_BUSY;
            S_BUSY:  if (dst_ready_i && !accept) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        for (int i = 0; i < N_MASTER; i++) begin
            src_ready_o[i] = accept && (gnt_idx == ID_W'(i));
        end
    end

    assign dst_valid_o = (state_q == S_BUSY);

    // Payload is only loaded on accept, so it holds through stalls and after drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_data_o <= '0;
            dst_last_o <= 1'b0;
            dst_id_o   <= '0;
            lock_q     <= LOCK_RST;
            lock_id_q  <= '0;
        end else if (accept) begin
            dst_data_o <= src_data_i[gnt_idx];
            dst_last_o <= src_last_i[gnt_idx];
            dst_id_o   <= gnt_idx;
            lock_q     <= !src_last_i[gnt_idx];
            if (!src_last_i[gnt_idx]) begin
                lock_id_q <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_dmac_rr_arbiter.sv
// Self-checking bench for dmac_rr_arbiter: directed scenarios plus randomized traffic vs a beat-level model.
module tb_dmac_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;
`ifdef DMAC_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          src_valid [N];
    logic          src_ready [N];
    logic [DW-1:0] src_data  [N];
    logic          src_last  [N];
    logic          dst_valid;
    logic          dst_ready;
    logic [DW-1:0] dst_data;
    logic          dst_last;
    logic [IW-1:0] dst_id;

    int n_checks = 0;
    int n_fail   = 0;

    bit            m_valid;
    bit            m_last;
    bit            m_locked;
    logic [DW-1:0] m_data;
    int            m_id;
    int            m_lock_id;
    int            m_last_id;

    always #5 clk = ~clk;

    dmac_rr_arbiter #(
        .N_MASTER  (N),
        .DATA_SIZE (DW),
        .ID_W      (IW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid_i (src_valid),
        .src_ready_o (src_ready),
        .src_data_i  (src_data),
        .src_last_i  (src_last),
        .dst_valid_o (dst_valid),
        .dst_ready_i (dst_ready),
        .dst_data_o  (dst_data),
        .dst_last_o  (dst_last),
        .dst_id_o    (dst_id)
    );

    task automatic model_reset();
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_locked  = 1'b0;
        m_data    = '0;
        m_id      = 0;
        m_lock_id = 0;
        m_last_id = N - 1;
    endtask

    // Which master the rules say is accepted right now, or -1.
    function automatic int exp_grant();
        int cand;
        if (!rst_n) return -1;
        if (m_valid && !dst_ready) return -1;
        if (m_locked) return (src_valid[m_lock_id] === 1'b1) ? m_lock_id : -1;
        for (int k = 0; k < N; k++) begin
            cand = RR ? (m_last_id + 1 + k) % N : k;
            if (src_valid[cand] === 1'b1) return cand;
        end
        return -1;
    endfunction

    // Index of the single asserted ready, -1 for none, -2 for more than one.
    function automatic int ready_idx();
        int r;
        r = -1;
        for (int i = 0; i < N; i++) begin
            if (src_ready[i] !== 1'b0) r = (r == -1) ? i : -2;
        end
        return r;
    endfunction

    task automatic tick();
        int g;
        g = exp_grant();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0) begin
            m_valid   = 1'b1;
            m_data    = src_data[g];
            m_last    = src_last[g];
            m_id      = g;
            m_last_id = g;
            m_locked  = !src_last[g];
            if (!src_last[g]) m_lock_id = g;
        end else if (dst_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_valid[i] = 1'b0;
            src_last[i]  = 1'b0;
            src_data[i]  = '0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            src_valid[i] = 1'b1;
            src_last[i]  = 1'b1;
            src_data[i]  = 32'hDEAD0000 + i;
        end
        dst_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dst_valid !== 1'b0 || dst_data !== '0 || dst_last !== 1'b0 || dst_id !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b data=%h last=%b id=%0d required 0/0/0/0", dst_valid, dst_data, dst_last, dst_id);
        end
        n_checks++;
        if (ready_idx() !== -1) begin
            n_fail++;
            $display("FAIL reset_ready: ready_idx=%0d required -1", ready_idx());
        end
        tick();
        tick();
        n_checks++;
        if (dst_valid !== 1'b0 || ready_idx() !== -1) begin
            n_fail++;
            $display("FAIL reset_held: valid=%b ready_idx=%0d required 0/-1", dst_valid, ready_idx());
        end
    endtask

    task automatic test_first_priority();
        int exp_g [5];
        int g;
`ifdef DMAC_ARB_RR_EN
        exp_g = '{0, 1, 2, 3, 0};
`else
        exp_g = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < N; i++) begin
            src_valid[i] = 1'b1;
            src_last[i]  = 1'b1;
            src_data[i]  = 32'h100 + i;
        end
        dst_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            g = ready_idx();
            n_checks++;
            if (g !== exp_g[k]) begin
                n_fail++;
                $display("FAIL first_grant[%0d]: got %0d required %0d", k, g, exp_g[k]);
            end
            if (k > 0) begin
                n_checks++;
                if (dst_valid !== 1'b1 || dst_id !== IW'(exp_g[k-1])) begin
                    n_fail++;
                    $display("FAIL first_dst[%0d]: valid=%b id=%0d required 1/%0d", k, dst_valid, dst_id, exp_g[k-1]);
                end
            end
            tick();
        end
        #1;
        n_checks++;
        if (dst_valid !== 1'b1 || dst_id !== IW'(exp_g[4])) begin
            n_fail++;
            $display("FAIL first_dst_final: valid=%b id=%0d required 1/%0d", dst_valid, dst_id, exp_g[4]);
        end
        clear_src();
        tick();
    endtask

    task automatic test_packet_lock();
        int g;
        for (int k = 0; k < 4; k++) begin
            src_valid[2] = 1'b1;
            src_data[2]  = 32'h2000 + k;
            src_last[2]  = (k == 3);
            src_valid[0] = (k > 0);
            src_last[0]  = 1'b1;
            src_data[0]  = 32'h0000BEEF;
            #1;
            g = ready_idx();
            n_checks++;
            if (g !== 2) begin
                n_fail++;
                $display("FAIL lock_grant[%0d]: got %0d required 2", k, g);
            end
            tick();
            #1;
            n_checks++;
            if (dst_id !== 2'd2 || dst_data !== 32'h2000 + k || dst_last !== (k == 3)) begin
                n_fail++;
                $display("FAIL lock_beat[%0d]: id=%0d data=%h last=%b required 2/%h/%0d", k, dst_id, dst_data, dst_last, 32'h2000 + k, k == 3);
            end
        end
        src_valid[2] = 1'b0;
        #1;
        g = ready_idx();
        n_checks++;
        if (g !== 0) begin
            n_fail++;
            $display("FAIL lock_release_grant: got %0d required 0", g);
        end
        tick();
        #1;
        n_checks++;
        if (dst_id !== 2'd0 || dst_data !== 32'h0000BEEF) begin
            n_fail++;
            $display("FAIL lock_release_beat: id=%0d data=%h required 0/0000beef", dst_id, dst_data);
        end
        clear_src();
        tick();
    endtask

    task automatic test_backpressure();
        int g;
        int exp_next;
        logic [DW-1:0] exp_data;
`ifdef DMAC_ARB_RR_EN
        exp_next = 3;
        exp_data = 32'h33333333;
`else
        exp_next = 1;
        exp_data = 32'h11111111;
`endif
        dst_ready    = 1'b1;
        src_valid[1] = 1'b1;
        src_data[1]  = 32'hA5A5A5A5;
        src_last[1]  = 1'b1;
        #1;
        n_checks++;
        if (ready_idx() !== 1) begin
            n_fail++;
            $display("FAIL bp_load_grant: got %0d required 1", ready_idx());
        end
        tick();
        src_data[1]  = 32'h11111111;
        src_valid[3] = 1'b1;
        src_data[3]  = 32'h33333333;
        src_last[3]  = 1'b1;
        dst_ready    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (ready_idx() !== -1) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: ready_idx=%0d required -1", k, ready_idx());
            end
            n_checks++;
            if (dst_valid !== 1'b1 || dst_data !== 32'hA5A5A5A5) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h required 1/a5a5a5a5", k, dst_valid, dst_data);
            end
            tick();
        end
        dst_ready = 1'b1;
        #1;
        g = ready_idx();
        n_checks++;
        if (g !== exp_next) begin
            n_fail++;
            $display("FAIL bp_resume_grant: got %0d required %0d", g, exp_next);
        end
        tick();
        #1;
        n_checks++;
        if (dst_valid !== 1'b1 || dst_data !== exp_data || dst_id !== IW'(exp_next)) begin
            n_fail++;
            $display("FAIL bp_resume_beat: valid=%b data=%h id=%0d required 1/%h/%0d", dst_valid, dst_data, dst_id, exp_data, exp_next);
        end
        clear_src();
        tick();
    endtask

    task automatic test_wrap();
        src_valid[3] = 1'b1;
        src_last[3]  = 1'b1;
        src_data[3]  = 32'h3333;
        #1;
        n_checks++;
        if (ready_idx() !== 3) begin
            n_fail++;
            $display("FAIL wrap_setup: got %0d required 3", ready_idx());
        end
        tick();
        clear_src();
        tick();
        src_valid[1] = 1'b1;
        src_last[1]  = 1'b1;
        src_data[1]  = 32'h1111;
        src_valid[3] = 1'b1;
        src_last[3]  = 1'b1;
        src_data[3]  = 32'h3333;
        #1;
        n_checks++;
        if (ready_idx() !== 1) begin
            n_fail++;
            $display("FAIL wrap_grant: got %0d required 1", ready_idx());
        end
        tick();
        #1;
        n_checks++;
        if (dst_id !== 2'd1 || dst_data !== 32'h1111) begin
            n_fail++;
            $display("FAIL wrap_beat: id=%0d data=%h required 1/00001111", dst_id, dst_data);
        end
        clear_src();
        tick();
    endtask

    task automatic test_async_reset();
        src_valid[1] = 1'b1;
        src_last[1]  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            src_data[1] = 32'h5100 + k;
            #1;
            n_checks++;
            if (ready_idx() !== 1) begin
                n_fail++;
                $display("FAIL areset_beat[%0d]: got %0d required 1", k, ready_idx());
            end
            tick();
        end
        src_data[1]  = 32'h5102;
        src_valid[0] = 1'b1;
        src_last[0]  = 1'b1;
        src_data[0]  = 32'h0A0A;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dst_valid !== 1'b0 || ready_idx() !== -1 || dst_data !== '0 || dst_id !== '0) begin
            n_fail++;
            $display("FAIL areset_immediate: valid=%b ready_idx=%0d data=%h id=%0d required 0/-1/0/0", dst_valid, ready_idx(), dst_data, dst_id);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ready_idx() !== 0) begin
            n_fail++;
            $display("FAIL areset_first_grant: got %0d required 0", ready_idx());
        end
        tick();
        #1;
        n_checks++;
        if (dst_id !== 2'd0 || dst_last !== 1'b1 || dst_data !== 32'h0A0A) begin
            n_fail++;
            $display("FAIL areset_first_beat: id=%0d last=%b data=%h required 0/1/00000a0a", dst_id, dst_last, dst_data);
        end
        clear_src();
        tick();
    endtask

    task automatic test_fixed_priority();
        int g;
        int e;
        for (int k = 0; k < 6; k++) begin
            src_valid[1] = 1'b1;
            src_last[1]  = 1'b1;
            src_data[1]  = 32'h1000 + k;
            src_valid[3] = 1'b1;
            src_last[3]  = 1'b1;
            src_data[3]  = 32'h3000 + k;
            #1;
            g = ready_idx();
            e = exp_grant();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL prio_grant[%0d]: got %0d required %0d", k, g, e);
            end
            tick();
            #1;
`ifndef DMAC_ARB_RR_EN
            n_checks++;
            if (dst_id !== 2'd1) begin
                n_fail++;
                $display("FAIL prio_fixed_id[%0d]: got %0d required 1", k, dst_id);
            end
`endif
            n_checks++;
            if (dst_id !== IW'(m_id) || dst_data !== m_data) begin
                n_fail++;
                $display("FAIL prio_beat[%0d]: id=%0d data=%h required %0d/%h", k, dst_id, dst_data, m_id, m_data);
            end
        end
        clear_src();
        tick();
    endtask

    task automatic test_random();
        int g;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                src_valid[i] = ($urandom_range(0, 9) < 6);
                src_last[i]  = ($urandom_range(0, 2) == 0);
                src_data[i]  = $urandom();
            end
            dst_ready = ($urandom_range(0, 9) < 7);
            #1;
            g = exp_grant();
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (src_ready[i] !== (g == i)) begin
                    n_fail++;
                    $display("FAIL rand_ready[%0d] cycle %0d: got %b required %0d", i, c, src_ready[i], g == i);
                end
            end
            n_checks++;
            if (dst_valid !== m_valid || dst_last !== m_last || dst_data !== m_data || dst_id !== IW'(m_id)) begin
                n_fail++;
                $display("FAIL rand_dst cycle %0d: valid=%b last=%b data=%h id=%0d required %0d/%0d/%h/%0d",
                         c, dst_valid, dst_last, dst_data, dst_id, m_valid, m_last, m_data, m_id);
            end
            tick();
        end
        clear_src();
        dst_ready = 1'b1;
        tick();
    endtask

    initial begin
        clear_src();
        dst_ready = 1'b0;
        model_reset();
        test_reset();
        test_first_priority();
        test_packet_lock();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_fixed_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
